flow_lookup_engine: RTL and testbench

Parametrised successor to the single-entry flow table. Holds `NUM_ENTRIES` programmable 5-tuple flow entries, matches every `flow_key` from `flow_key_gen` against all valid entries in a fully pipelined 2-cycle lookup, and returns hit/flow_id with lowest-index priority. Keeps saturating per-entry hit counters plus global lookup and miss counters, readable over the AXI-Lite decode path. Sits between `flow_key_gen` and `axi_addr_decode`, replacing `flow_table`.

---
 rtl/flow_lookup_if.sv | 30 +++
 rtl/flow_lookup_engine.sv | 171 +++++++++++++++++
 tb/tb_flow_lookup_engine.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_lookup_if.sv
// Bundle for the flow lookup engine: key stream in, lookup results out,
// and the byte-addressed config write/read strobes with their acknowledges.
interface flow_lookup_if #(
   parameter int KEY_WIDTH = 128,
   parameter int ID_WIDTH  = 16
);
   logic [KEY_WIDTH-1:0] flow_key;
   logic                 flow_key_valid;
   logic [7:0]           waddr;
   logic [31:0]          wdata;
   logic                 we;
   logic                 wdone;
   logic [7:0]           raddr;
   logic                 re;
   logic [31:0]          rdata;
   logic                 rdone;
   logic                 result_valid;
   logic                 flow_hit;
   logic [ID_WIDTH-1:0]  flow_id;

   modport master (
      output flow_key, flow_key_valid, waddr, wdata, we, raddr, re,
      input  wdone, rdata, rdone, result_valid, flow_hit, flow_id
   );

   modport slave (
      input  flow_key, flow_key_valid, waddr, wdata, we, raddr, re,
      output wdone, rdata, rdone, result_valid, flow_hit, flow_id
   );
endinterface

// File: rtl/flow_lookup_engine.sv
// Multi-entry 5-tuple flow table: 2-stage pipelined match with lowest-index
// priority, saturating hit/miss/lookup counters, and a small config reg-file.
module flow_lookup_engine #(
   parameter int NUM_ENTRIES = 8,
   parameter int KEY_WIDTH   = 128,
   parameter int ID_WIDTH    = 16,
   parameter int CNT_WIDTH   = 32
) (
   input logic          clk,
   input logic          rst,
   flow_lookup_if.slave bus
);
   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [8:0] ENTRY_LIM = 9'(NUM_ENTRIES);

   logic [KEY_WIDTH-1:0] stage_key;
   logic [ID_WIDTH-1:0]  stage_id;
   logic                 enable;
   logic [7:0]           sel;

   logic [KEY_WIDTH-1:0]   entry_key [NUM_ENTRIES];
   logic [ID_WIDTH-1:0]    entry_id  [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] entry_valid;

   logic                   v0, v1;
   logic [KEY_WIDTH-1:0]   key_q;
   logic [NUM_ENTRIES-1:0] match_d, match_q;
   logic                   enc_hit;
   logic [IDX_W-1:0]       enc_idx;
   logic                   res_valid, res_hit;
   logic [ID_WIDTH-1:0]    res_id;

   logic [NUM_ENTRIES-1:0][CNT_WIDTH-1:0] hit_cnt;
   logic [CNT_WIDTH-1:0]   miss_cnt, lookup_cnt;

   logic        wdone_q, rdone_q;
   logic [31:0] rdata_q, rd_mux;

   logic wr_key, wr_id, wr_commit, wr_ctrl, wr_sel, commit_ok, clr, sel_ok;

   assign wr_key    = bus.we && (bus.waddr[7:4] == 4'h0) && (bus.waddr[1:0] == 2'b00);
   assign wr_id     = bus.we && (bus.waddr == 8'h10);
   assign wr_commit = bus.we && (bus.waddr == 8'h14);
   assign wr_ctrl   = bus.we && (bus.waddr == 8'h18);
   assign wr_sel    = bus.we && (bus.waddr == 8'h20);
   assign commit_ok = ({1'b0, bus.wdata[7:0]} < ENTRY_LIM);
   assign clr       = wr_ctrl && bus.wdata[0];
   assign sel_ok    = ({1'b0, sel} < ENTRY_LIM);

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_key   <= '0;
         stage_id    <= '0;
         enable      <= 1'b1;
         sel         <= '0;
         entry_valid <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_key[i] <= '0;
            entry_id[i]  <= '0;
         end
      end else begin
         if (wr_key)
            stage_key[{bus.waddr[3:2], 5'b0} +: 32] <= bus.wdata;
         if (wr_id)
            stage_id <= bus.wdata[ID_WIDTH-1:0];
         if (wr_ctrl)
            enable <= bus.wdata[1];
         if (wr_sel)
            sel <= bus.wdata[7:0];
         // Out-of-range commits are dropped silently; wdone still acks them.
         if (wr_commit && commit_ok) begin
            entry_key[bus.wdata[IDX_W-1:0]]   <= stage_key;
            entry_id[bus.wdata[IDX_W-1:0]]    <= stage_id;
            entry_valid[bus.wdata[IDX_W-1:0]] <= bus.wdata[31];
         end
      end
   end

   // Stage 1 compares against the live table, so a commit landing on the
   // same edge as the key sample is seen by that key, a later one is not.
   always_comb begin
      match_d = '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
         match_d[i] = entry_valid[i] && (key_q == entry_key[i]);
   end

   always_comb begin
      enc_hit = 1'b0;
      enc_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (match_q[i]) begin
            enc_hit = 1'b1;
            enc_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v0        <= 1'b0;
         v1        <= 1'b0;
         key_q     <= '0;
         match_q   <= '0;
         res_valid <= 1'b0;
         res_hit   <= 1'b0;
         res_id    <= '0;
      end else begin
         v0 <= bus.flow_key_valid && enable;
         if (bus.flow_key_valid && enable)
            key_q <= bus.flow_key;
         v1        <= v0;
         match_q   <= v0 ? match_d : '0;
         res_valid <= v1;
         res_hit   <= v1 && enc_hit;
         res_id    <= (v1 && enc_hit) ? entry_id[enc_idx] : '0;
      end
   end

   // Counters bump on the edge the result is registered; a clear on that
   // same edge takes precedence.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hit_cnt    <= '0;
         miss_cnt   <= '0;
         lookup_cnt <= '0;
      end else if (v1) begin
         if (lookup_cnt != '1)
            lookup_cnt <= lookup_cnt + CNT_ONE;
         if (enc_hit) begin
            if (hit_cnt[enc_idx] != '1)
               hit_cnt[enc_idx] <= hit_cnt[enc_idx] + CNT_ONE;
         end else if (miss_cnt != '1) begin
            miss_cnt <= miss_cnt + CNT_ONE;
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.raddr)
         8'h18:   rd_mux = {30'b0, enable, 1'b0};
         8'h20:   rd_mux = {24'b0, sel};
         8'h24:   rd_mux = sel_ok ? 32'(hit_cnt[sel[IDX_W-1:0]]) : 32'b0;
         8'h28:   rd_mux = 32'(miss_cnt);
         8'h2C:   rd_mux = 32'(lookup_cnt);
         8'h30:   rd_mux = 32'(NUM_ENTRIES);
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdone_q <= 1'b0;
         rdone_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         wdone_q <= bus.we;
         rdone_q <= bus.re;
         rdata_q <= bus.re ? rd_mux : 32'b0;
      end
   end

   assign bus.wdone        = wdone_q;
   assign bus.rdone        = rdone_q;
   assign bus.rdata        = rdata_q;
   assign bus.result_valid = res_valid;
   assign bus.flow_hit     = res_hit;
   assign bus.flow_id      = res_id;

endmodule

// File: tb/tb_flow_lookup_engine.sv
// Scoreboard bench for flow_lookup_engine: a table model predicts each lookup
// when the key is driven; a negedge monitor pops and compares every result.
module tb_flow_lookup_engine;
   localparam logic [127:0] KEY_A = {24'h0, 32'h0A000001, 32'h0A000002, 8'h11, 16'h1234, 16'h5678};
   localparam logic [127:0] KEY_B = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
   localparam logic [127:0] KEY_C = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

   logic clk, rst;
   int   checks, errors, rv_count;

   flow_lookup_if #(.KEY_WIDTH(128), .ID_WIDTH(16)) bus ();

   flow_lookup_engine #(.NUM_ENTRIES(8), .KEY_WIDTH(128), .ID_WIDTH(16), .CNT_WIDTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        hit;
      logic [15:0] id;
      int          idx;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   logic         m_valid [8];
   logic [127:0] m_key [8];
   logic [15:0]  m_id [8];
   logic [31:0]  m_hit [8];
   logic [127:0] m_skey;
   logic [15:0]  m_sid;
   logic         m_en;
   logic [31:0]  m_miss, m_lookup;
   logic [255:0] sat_pre;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic void model_clear_cnt();
      for (int i = 0; i < 8; i++) m_hit[i] = '0;
      m_miss = '0;
      m_lookup = '0;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_key[i] = '0;
         m_id[i] = '0;
      end
      m_skey = '0;
      m_sid = '0;
      m_en = 1'b1;
      model_clear_cnt();
   endfunction

   function automatic void model_wr(input logic [7:0] a, input logic [31:0] d);
      case (a)
         8'h00, 8'h04, 8'h08, 8'h0C: m_skey[{a[3:2], 5'b0} +: 32] = d;
         8'h10: m_sid = d[15:0];
         8'h14: if (d[7:0] < 8'd8) begin
            m_key[d[2:0]] = m_skey;
            m_id[d[2:0]] = m_sid;
            m_valid[d[2:0]] = d[31];
         end
         8'h18: begin
            m_en = d[1];
            if (d[0]) model_clear_cnt();
         end
         default: ;
      endcase
   endfunction

   function automatic void push_exp(input logic [127:0] k);
      exp_t e;
      e.hit = 1'b0;
      e.id = '0;
      e.idx = 0;
      for (int i = 7; i >= 0; i--) begin
         if (m_valid[i] && m_key[i] == k) begin
            e.hit = 1'b1;
            e.id = m_id[i];
            e.idx = i;
         end
      end
      exp_q.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (bus.result_valid === 1'b1) begin
         rv_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result hit=%0b id=%h required=no result", bus.flow_hit, bus.flow_id);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.flow_hit, bus.flow_id} !== {mon_e.hit, mon_e.id}) begin
               errors++;
               $display("FAIL lookup_result hit=%0b id=%h required hit=%0b id=%h",
                        bus.flow_hit, bus.flow_id, mon_e.hit, mon_e.id);
            end
            m_lookup = sat_inc(m_lookup);
            if (mon_e.hit) m_hit[mon_e.idx] = sat_inc(m_hit[mon_e.idx]);
            else m_miss = sat_inc(m_miss);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus.waddr = a;
      bus.wdata = d;
      bus.we = 1'b1;
      tick();
      bus.we = 1'b0;
      model_wr(a, d);
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic dn);
      bus.raddr = a;
      bus.re = 1'b1;
      tick();
      bus.re = 1'b0;
      d = bus.rdata;
      dn = bus.rdone;
   endtask

   task automatic send_key(input logic [127:0] k);
      bus.flow_key = k;
      bus.flow_key_valid = 1'b1;
      if (m_en) push_exp(k);
      tick();
      bus.flow_key_valid = 1'b0;
   endtask

   task automatic load_stage(input logic [127:0] k, input logic [15:0] id);
      wr(8'h00, k[31:0]);
      wr(8'h04, k[63:32]);
      wr(8'h08, k[95:64]);
      wr(8'h0C, k[127:96]);
      wr(8'h10, {16'h0, id});
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic dn;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      model_reset();
      checks++;
      if ({bus.result_valid, bus.flow_hit, bus.flow_id, bus.wdone, bus.rdone, bus.rdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs rv=%0b hit=%0b id=%h wdone=%0b rdone=%0b rdata=%h required all 0",
                  bus.result_valid, bus.flow_hit, bus.flow_id, bus.wdone, bus.rdone, bus.rdata);
      end
      rd(8'h28, d, dn);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_miss_cnt got=%h required=0", d); end
      rd(8'h2C, d, dn);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_lookup_cnt got=%h required=0", d); end
      rd(8'h30, d, dn);
      checks++;
      if (d !== 32'd8 || dn !== 1'b1) begin errors++; $display("FAIL reset_num_entries got=%h rdone=%0b required=8 rdone=1", d, dn); end
      rd(8'h18, d, dn);
      checks++;
      if (d !== 32'd2) begin errors++; $display("FAIL reset_ctrl got=%h required=2", d); end
      rd(8'h20, d, dn);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_sel got=%h required=0", d); end

      // Latency: key sampled at edge N, result visible only after edge N+2.
      send_key(KEY_C);
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL latency_n0 rv=%0b required=0", bus.result_valid); end
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL latency_n1 rv=%0b required=0", bus.result_valid); end
      @(negedge clk);
      checks++;
      if ({bus.result_valid, bus.flow_hit, bus.flow_id} !== {1'b1, 1'b0, 16'h0}) begin
         errors++;
         $display("FAIL latency_n2 rv=%0b hit=%0b id=%h required rv=1 hit=0 id=0", bus.result_valid, bus.flow_hit, bus.flow_id);
      end
      @(posedge clk);
      #1;
      drain("reset_lookup");
      rd(8'h28, d, dn);
      checks++;
      if (d !== 32'd1) begin errors++; $display("FAIL first_miss_cnt got=%h required=1", d); end
   endtask

   task automatic test_program_hit();
      logic [31:0] d;
      logic dn;
      load_stage(KEY_A, 16'h0042);
      wr(8'h14, 32'h8000_0003);
      checks++;
      if (bus.wdone !== 1'b1) begin errors++; $display("FAIL commit_wdone got=%0b required=1", bus.wdone); end
      for (int i = 0; i < 4; i++) send_key(KEY_A);
      drain("b2b_hits");
      wr(8'h20, 32'd3);
      rd(8'h24, d, dn);
      checks++;
      if (d !== 32'd4 || d !== m_hit[3]) begin errors++; $display("FAIL hit_cnt_entry3 got=%h required=4", d); end
      rd(8'h2C, d, dn);
      checks++;
      if (d !== 32'd5 || d !== m_lookup) begin errors++; $display("FAIL lookup_cnt_after_b2b got=%h required=5", d); end
   endtask

   task automatic test_priority();
      wr(8'h10, 32'd7);
      wr(8'h14, 32'h8000_0005);
      wr(8'h10, 32'd9);
      wr(8'h14, 32'h8000_0002);
      send_key(KEY_A);
      drain("priority_lowest");
      wr(8'h14, 32'h0000_0002);
      send_key(KEY_A);
      drain("priority_after_invalidate");
   endtask

   task automatic test_commit_timing();
      wr(8'h14, 32'h0000_0005);
      wr(8'h10, 32'h0000_0042);
      // Invalidate entry 3 on the same edge its key is sampled: miss.
      bus.waddr = 8'h14;
      bus.wdata = 32'h0000_0003;
      bus.we = 1'b1;
      bus.flow_key = KEY_A;
      bus.flow_key_valid = 1'b1;
      model_wr(8'h14, 32'h0000_0003);
      push_exp(KEY_A);
      tick();
      bus.we = 1'b0;
      bus.flow_key_valid = 1'b0;
      drain("commit_same_cycle");
      wr(8'h14, 32'h8000_0003);
      send_key(KEY_A);
      wr(8'h14, 32'h0000_0003);
      drain("commit_next_cycle");
   endtask

   task automatic test_saturation();
      logic [31:0] d;
      logic dn;
      load_stage(KEY_B, 16'h0011);
      wr(8'h14, 32'h8000_0000);
      wr(8'h18, 32'h0000_0003);
      sat_pre = '0;
      sat_pre[31:0] = 32'hFFFF_FFFE;
      force dut.hit_cnt = sat_pre;
      tick();
      release dut.hit_cnt;
      m_hit[0] = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) send_key(KEY_B);
      drain("sat_hits");
      wr(8'h20, 32'd0);
      rd(8'h24, d, dn);
      checks++;
      if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL hit_cnt_saturate got=%h required=ffffffff", d); end

      // Clear lands on the same edge as the increment for this hit.
      send_key(KEY_B);
      tick();
      bus.waddr = 8'h18;
      bus.wdata = 32'h0000_0003;
      bus.we = 1'b1;
      tick();
      bus.we = 1'b0;
      drain("clear_vs_inc");
      model_clear_cnt();
      rd(8'h24, d, dn);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL clear_wins_hit got=%h required=0", d); end
      rd(8'h2C, d, dn);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL clear_wins_lookup got=%h required=0", d); end
      rd(8'h18, d, dn);
      checks++;
      if (d !== 32'd2) begin errors++; $display("FAIL ctrl_clear_not_stored got=%h required=2", d); end
   endtask

   task automatic test_misc();
      logic [31:0] d;
      logic dn;
      int rv0;
      load_stage(KEY_C, 16'h0055);
      wr(8'h14, 32'h8000_00C8);
      checks++;
      if (bus.wdone !== 1'b1) begin errors++; $display("FAIL commit_oob_wdone got=%0b required=1", bus.wdone); end
      send_key(KEY_C);
      send_key(KEY_B);
      drain("commit_oob_lookup");
      wr(8'h3C, 32'hFFFF_FFFF);
      checks++;
      if (bus.wdone !== 1'b1) begin errors++; $display("FAIL unmapped_wdone got=%0b required=1", bus.wdone); end
      rd(8'h3C, d, dn);
      checks++;
      if (d !== 32'd0 || dn !== 1'b1) begin errors++; $display("FAIL unmapped_read got=%h rdone=%0b required=0 rdone=1", d, dn); end

      bus.waddr = 8'h20;
      bus.wdata = 32'd5;
      bus.we = 1'b1;
      bus.raddr = 8'h30;
      bus.re = 1'b1;
      tick();
      bus.we = 1'b0;
      bus.re = 1'b0;
      checks++;
      if ({bus.wdone, bus.rdone, bus.rdata} !== {1'b1, 1'b1, 32'd8}) begin
         errors++;
         $display("FAIL simul_we_re wdone=%0b rdone=%0b rdata=%h required 1 1 00000008", bus.wdone, bus.rdone, bus.rdata);
      end
      rd(8'h20, d, dn);
      checks++;
      if (d !== 32'd5) begin errors++; $display("FAIL sel_readback got=%h required=5", d); end
      rd(8'h24, d, dn);
      checks++;
      if (d !== m_hit[5]) begin errors++; $display("FAIL hit_cnt_entry5 got=%h required=%h", d, m_hit[5]); end
      wr(8'h20, 32'd8);
      rd(8'h24, d, dn);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL sel_out_of_range got=%h required=0", d); end

      wr(8'h18, 32'h0000_0000);
      rd(8'h18, d, dn);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL ctrl_disabled got=%h required=0", d); end
      rv0 = rv_count;
      send_key(KEY_B);
      repeat (6) tick();
      checks++;
      if (rv_count != rv0) begin errors++; $display("FAIL disabled_lookup results=%0d required=0", rv_count - rv0); end
      wr(8'h18, 32'h0000_0002);
   endtask

   task automatic test_reset_flush();
      logic [31:0] d;
      logic dn;
      int rv0;
      rv0 = rv_count;
      bus.flow_key = KEY_B;
      bus.flow_key_valid = 1'b1;
      tick();
      bus.flow_key = KEY_C;
      tick();
      bus.flow_key_valid = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      repeat (6) tick();
      checks++;
      if (rv_count != rv0) begin errors++; $display("FAIL reset_flush results=%0d required=0", rv_count - rv0); end
      rd(8'h2C, d, dn);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_flush_lookup_cnt got=%h required=0", d); end
      send_key(KEY_B);
      drain("post_reset_lookup");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rv_count = 0;
      rst = 1'b1;
      bus.flow_key = '0;
      bus.flow_key_valid = 1'b0;
      bus.waddr = '0;
      bus.wdata = '0;
      bus.we = 1'b0;
      bus.raddr = '0;
      bus.re = 1'b0;
      model_reset();
      test_reset();
      test_program_hit();
      test_priority();
      test_commit_timing();
      test_saturation();
      test_misc();
      test_reset_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
